// File: rtl/frame_rx.sv
// -----------------------------------------------------------------------------
// frame_rx : receive-side deframer for a byte-wide txd/tx_en stream.
//
// Strips 0x55 preamble and 0xD5 SFD, forwards the frame data bytes with
// sop/eop framing, checks the IEEE 802.3 CRC32 FCS and the body length, and
// keeps saturating good/bad frame counters.
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   txd, tx_en    : incoming byte and frame-active qualifier
//   out_data      : forwarded data byte (0 when out_valid=0)
//   out_valid     : out_data valid, one cycle per byte
//   out_sop       : first data byte of the frame
//   out_eop       : last data byte of the frame
//   frame_done    : one-cycle end-of-frame status pulse
//   frame_ok      : with frame_done, 1 = frame had no error
//   err_code      : with frame_done, 0 OK, 1 CRC, 2 RUNT, 3 GIANT, 4 BAD_PRE
//   frm_cnt       : good-frame count, saturating at 0xFFFF
//   err_cnt       : bad-frame count, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module frame_rx #(
  parameter int PRE_MIN = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  txd,
  input  logic        tx_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [2:0]  err_code,
  output logic [15:0] frm_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [3:0]  PRE_M = 4'(PRE_MIN);
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  localparam logic [2:0] E_OK    = 3'd0;
  localparam logic [2:0] E_CRC   = 3'd1;
  localparam logic [2:0] E_RUNT  = 3'd2;
  localparam logic [2:0] E_GIANT = 3'd3;
  localparam logic [2:0] E_PRE   = 3'd4;

  typedef enum logic [1:0] {IDLE, PRE, BODY, DROP} state_t;

  state_t state, state_nx;
  logic [3:0] pre_cnt, pre_cnt_nx;

  // Delay line: dl[4] is the newest byte, dl[0] the oldest once 5 are held.
  // Holding back 5 bytes means that when tx_en drops, dl[0] is the last data
  // byte and dl[1..4] are the FCS in arrival order.
  logic [4:0][7:0] dl;
  logic [10:0]     len;      // body bytes seen (data + FCS), saturating
  logic [31:0]     crc;      // running CRC over bytes already forwarded
  logic            first;    // next forwarded byte is byte 0 of the frame

  // Control decoded by the FSM
  logic       shift;         // accept txd into the delay line
  logic       clr;           // flush line/len/crc at frame start and end
  logic       emit;          // forward dl[0] this edge
  logic       eop;           // forwarded byte is the last data byte
  logic       done;          // end-of-frame status this edge
  logic [2:0] code;

  logic        full;
  logic [31:0] crc_in;       // crc with dl[0] folded in
  logic [31:0] fcs_rx;

  function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                           input logic [7:0]  d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign full   = (len >= 11'd5);
  assign crc_in = crc_byte(crc, dl[0]);
  assign fcs_rx = {dl[4], dl[3], dl[2], dl[1]};

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pre_cnt <= 4'd0;
    end else begin
      state   <= state_nx;
      pre_cnt <= pre_cnt_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    pre_cnt_nx = pre_cnt;
    shift      = 1'b0;
    clr        = 1'b0;
    emit       = 1'b0;
    eop        = 1'b0;
    done       = 1'b0;
    code       = E_OK;

    unique case (state)
      IDLE: begin
        if (tx_en) begin
          if (txd == 8'h55) begin
            state_nx   = PRE;
            pre_cnt_nx = 4'd1;
          end else begin
            state_nx = DROP;
          end
        end
      end

      PRE: begin
        if (!tx_en) begin
          state_nx = IDLE;
          done     = 1'b1;
          code     = E_PRE;
        end else if (txd == 8'h55) begin
          pre_cnt_nx = (pre_cnt == 4'hF) ? pre_cnt : pre_cnt + 4'd1;
        end else if (txd == 8'hD5 && pre_cnt >= PRE_M) begin
          state_nx = BODY;
          clr      = 1'b1;
        end else begin
          state_nx = DROP;
        end
      end

      DROP: begin
        if (!tx_en) begin
          state_nx = IDLE;
          done     = 1'b1;
          code     = E_PRE;
        end
      end

      BODY: begin
        if (tx_en) begin
          shift = 1'b1;
          emit  = full;            // line full: oldest byte leaves
        end else begin
          state_nx = IDLE;
          clr      = 1'b1;
          done     = 1'b1;
          emit     = full;
          eop      = full;
          if (!full)
            code = E_RUNT;         // nothing but FCS bytes (or less)
          else if (len > MAX_L)
            code = E_GIANT;
          else if (len < MIN_L)
            code = E_RUNT;
          else if (~crc_in != fcs_rx)
            code = E_CRC;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath, registered outputs and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dl         <= '0;
      len        <= '0;
      crc        <= 32'hFFFFFFFF;
      first      <= 1'b1;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= '0;
      frm_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      out_valid  <= emit;
      out_data   <= emit ? dl[0] : 8'h00;
      out_sop    <= emit & first;
      out_eop    <= eop;
      frame_done <= done;
      frame_ok   <= done && (code == E_OK);
      err_code   <= done ? code : E_OK;

      if (emit) begin
        crc   <= crc_in;
        first <= 1'b0;
      end

      if (shift) begin
        dl <= {txd, dl[4:1]};
        if (len != 11'h7FF)
          len <= len + 11'd1;
      end

      // Placed after the updates above so a flush wins at eop.
      if (clr) begin
        dl    <= '0;
        len   <= '0;
        crc   <= 32'hFFFFFFFF;
        first <= 1'b1;
      end

      if (frame_done && frame_ok && frm_cnt != 16'hFFFF)
        frm_cnt <= frm_cnt + 16'd1;
      if (frame_done && !frame_ok && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_frame_rx : scoreboard bench for frame_rx. Stimulus tasks push expected
// bytes and frame statuses into queues; a monitor process pops and compares
// whenever the DUT presents a byte or a frame_done pulse.
// -----------------------------------------------------------------------------
module tb_frame_rx;

  localparam int PRE_MIN = 2;
  localparam int MIN_L   = 8;
  localparam int MAX_L   = 1518;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  txd;
  logic        tx_en;
  logic [7:0]  out_data;
  logic        out_valid, out_sop, out_eop;
  logic        frame_done, frame_ok;
  logic [2:0]  err_code;
  logic [15:0] frm_cnt, err_cnt;

  frame_rx #(.PRE_MIN(PRE_MIN), .MIN_LEN(MIN_L), .MAX_LEN(MAX_L)) dut (
    .clk(clk), .rst(rst), .txd(txd), .tx_en(tx_en),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .frame_done(frame_done), .frame_ok(frame_ok),
    .err_code(err_code), .frm_cnt(frm_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] d; logic sop; logic eop; } byte_t;
  typedef struct { logic [2:0] code; int frm; int err; } stat_t;

  byte_t exp_b[$];
  stat_t exp_s[$];
  int    m_frm = 0, m_err = 0;
  int    errors = 0, checks = 0;
  bit    pend = 1'b0;
  stat_t ps;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit-serial CRC32 straight from the definition; returns the FCS value.
  function automatic logic [31:0] crc32(input bq_t q);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (q[i])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  function automatic bq_t make_body(input bq_t data, input bit corrupt);
    bq_t b;
    logic [31:0] c;
    b = data;
    c = crc32(data);
    b.push_back(c[7:0]);  b.push_back(c[15:8]);
    b.push_back(c[23:16]); b.push_back(c[31:24]);
    if (corrupt) b[b.size()-1] = b[b.size()-1] ^ 8'h01;
    return b;
  endfunction

  // Reference model: what a body (bytes between SFD and tx_en drop) produces.
  task automatic expect_body(input bq_t body);
    int n;
    bq_t data;
    stat_t s;
    byte_t e;
    logic [31:0] fcs;
    n = body.size();
    if (n <= 4) s.code = 3'd2;
    else begin
      for (int i = 0; i < n - 4; i++) begin
        data.push_back(body[i]);
        e.d = body[i]; e.sop = (i == 0); e.eop = (i == n - 5);
        exp_b.push_back(e);
      end
      fcs = {body[n-1], body[n-2], body[n-3], body[n-4]};
      if (n > MAX_L)                s.code = 3'd3;
      else if (n < MIN_L)           s.code = 3'd2;
      else if (crc32(data) != fcs)  s.code = 3'd1;
      else                          s.code = 3'd0;
    end
    if (s.code == 3'd0) m_frm++; else m_err++;
    s.frm = m_frm; s.err = m_err;
    exp_s.push_back(s);
  endtask

  task automatic expect_bad();
    stat_t s;
    m_err++;
    s.code = 3'd4; s.frm = m_frm; s.err = m_err;
    exp_s.push_back(s);
  endtask

  task automatic cyc(input logic en, input logic [7:0] d);
    tx_en = en; txd = d;
    @(posedge clk); #1;
  endtask

  task automatic send_raw(input bq_t q, input int gap);
    foreach (q[i]) cyc(1'b1, q[i]);
    repeat (gap) cyc(1'b0, 8'h00);
  endtask

  task automatic send(input int npre, input bq_t body, input int gap);
    bq_t q;
    repeat (npre) q.push_back(8'h55);
    q.push_back(8'hD5);
    foreach (body[i]) q.push_back(body[i]);
    send_raw(q, gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_b.size() != 0 || exp_s.size() != 0 || pend) && t < 5000) begin
      @(posedge clk); t++;
    end
    #1;
    checks++;
    if (t >= 5000) begin
      errors++;
      $display("FAIL drain: %0d bytes and %0d statuses still pending", exp_b.size(), exp_s.size());
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    byte_t eb;
    stat_t es;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("frm_cnt", 32'(frm_cnt), 32'(ps.frm));
        chk("err_cnt", 32'(err_cnt), 32'(ps.err));
        pend = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got %0h expected none", out_data);
        end else begin
          eb = exp_b.pop_front();
          chk("out_data", 32'(out_data), 32'(eb.d));
          chk("out_sop", 32'(out_sop), 32'(eb.sop));
          chk("out_eop", 32'(out_eop), 32'(eb.eop));
        end
      end else if (out_sop === 1'b1 || out_eop === 1'b1) begin
        checks++; errors++;
        $display("FAIL framing_without_valid: sop=%0b eop=%0b expected 0", out_sop, out_eop);
      end
      if (frame_done === 1'b1) begin
        if (exp_s.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_done: code=%0d expected none", err_code);
        end else begin
          es = exp_s.pop_front();
          chk("err_code", 32'(err_code), 32'(es.code));
          chk("frame_ok", 32'(frame_ok), 32'(es.code == 3'd0));
          ps = es; pend = 1'b1;
        end
      end
    end
  end

  initial begin : stim
    bq_t data, body, raw;
    int  kind, gap, n;
    logic [7:0] x;

    rst = 1'b1; tx_en = 1'b0; txd = 8'h00;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_sop_eop", 32'({out_sop, out_eop}), 0);
    chk("rst_frame_done", 32'({frame_done, frame_ok}), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_frm_cnt", 32'(frm_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst = 1'b0;
    cyc(1'b0, 8'h00);

    // Known vector "123456789" with fixed FCS 26 39 F4 CB
    body = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,
             8'h26,8'h39,8'hF4,8'hCB};
    expect_body(body); send(7, body, 1);
    body[12] = 8'hCA;
    expect_body(body); send(7, body, 1);
    drain();

    // Runt with data forwarded, then 3-byte body, then exactly 5-byte body
    data = '{8'hA1, 8'hA2};
    body = make_body(data, 1'b0); expect_body(body); send(7, body, 1);
    body = '{8'h01, 8'h02, 8'h03}; expect_body(body); send(7, body, 1);
    data = '{8'h5A};
    body = make_body(data, 1'b0); expect_body(body); send(3, body, 1);
    body = '{};                   expect_body(body); send(2, body, 1);

    // Bad preambles
    raw = '{8'h55, 8'hD5, 8'h11, 8'h22, 8'h33}; expect_bad(); send_raw(raw, 1);
    raw = '{8'h55, 8'h12, 8'h34};               expect_bad(); send_raw(raw, 1);
    raw = '{8'hA0, 8'h55, 8'hD5, 8'h01};        expect_bad(); send_raw(raw, 2);
    raw = '{8'h55, 8'h55, 8'h55};               expect_bad(); send_raw(raw, 1);
    drain();

    // Back-to-back good frames with 1-cycle gaps, long preamble saturating
    for (int f = 0; f < 3; f++) begin
      data = '{};
      for (int i = 0; i < 8 + f; i++) data.push_back(8'(16 * f + i));
      body = make_body(data, 1'b0); expect_body(body);
      send((f == 2) ? 20 : 7, body, 1);
    end
    drain();

    // Giant: 1600-byte body
    data = '{};
    for (int i = 0; i < 1596; i++) data.push_back(8'($urandom));
    body = make_body(data, 1'b0); expect_body(body); send(7, body, 2);
    drain();

    // Reset mid-BODY: bytes 0..4 come out before the reset edge, nothing after
    data = '{};
    for (int i = 0; i < 10; i++) data.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) begin
      byte_t e;
      e.d = data[i]; e.sop = (i == 0); e.eop = 1'b0;
      exp_b.push_back(e);
    end
    send(7, data, 0);
    rst = 1'b1; cyc(1'b1, 8'h77);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_frame_done", 32'(frame_done), 0);
    chk("midrst_sop_eop", 32'({out_sop, out_eop}), 0);
    chk("midrst_counters", 32'({frm_cnt, err_cnt}), 0);
    rst = 1'b0; m_frm = 0; m_err = 0;
    cyc(1'b0, 8'h00); cyc(1'b0, 8'h00);
    data = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    body = make_body(data, 1'b0); expect_body(body); send(7, body, 1);
    drain();

    // Randomized mix
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(1, 3);
      if (kind <= 5) begin
        n = $urandom_range(1, 30);
        data = '{};
        for (int i = 0; i < n; i++) data.push_back(8'($urandom));
        body = make_body(data, kind == 5);
        expect_body(body); send($urandom_range(2, 9), body, gap);
      end else if (kind <= 7) begin
        n = $urandom_range(0, 4);
        body = '{};
        for (int i = 0; i < n; i++) body.push_back(8'($urandom));
        expect_body(body); send($urandom_range(2, 9), body, gap);
      end else begin
        x = 8'($urandom);
        if (x == 8'h55 || x == 8'hD5) x = 8'h00;
        raw = (kind == 8) ? '{8'h55, 8'hD5} : '{8'h55, 8'h55, 8'h55, x};
        for (int i = 0; i < 3; i++) raw.push_back(8'($urandom));
        expect_bad(); send_raw(raw, gap);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_rx.md
Name: frame_rx

Overview:
- Receive-side deframer for the byte-wide stream the dut drives out on txd/tx_en.
- Strips preamble/SFD, forwards frame data bytes with sop/eop framing, checks IEEE 802.3 CRC32 FCS and length, and keeps good/bad frame counters.
- Serves as the far end of the dut transmit interface, in RTL checkers and loopback benches.

Parameters:
- PRE_MIN, 2: minimum 0x55 preamble bytes before SFD.
- MIN_LEN, 64: minimum body length in bytes (data + 4-byte FCS).
- MAX_LEN, 1518: maximum body length in bytes (data + FCS).

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- txd  input  8  incoming byte, sampled when tx_en=1.
- tx_en  input  1  frame-active qualifier.
- out_data  output  8  forwarded data byte.
- out_valid  output  1  out_data valid.
- out_sop  output  1  first data byte of frame.
- out_eop  output  1  last data byte of frame.
- frame_done  output  1  one-cycle end-of-frame status pulse.
- frame_ok  output  1  valid with frame_done; 1 = no error.
- err_code  output  3  valid with frame_done: 0 OK, 1 CRC, 2 RUNT, 3 GIANT, 4 BAD_PRE.
- frm_cnt  output  16  good-frame count, saturating.
- err_cnt  output  16  bad-frame count, saturating.

Behaviour:
- Reset (synchronous, active-high): state IDLE; delay line, CRC and length counter cleared; all outputs 0.
  - Reset mid-frame aborts the frame with no frame_done.
  - rst dominates tx_en.
- States: IDLE, PRE, BODY, DROP.
- IDLE:
  - tx_en=1 with txd=0x55 → PRE, pre_cnt=1.
  - tx_en=1 with any other txd → DROP.
- PRE:
  - txd=0x55: pre_cnt++ (saturates at 15).
  - txd=0xD5 with pre_cnt>=PRE_MIN → BODY.
  - Any other byte, or 0xD5 with pre_cnt<PRE_MIN → DROP.
  - tx_en=0 → IDLE; frame_done with err_code=4.
- DROP: ignore bytes; on tx_en=0 → IDLE; frame_done with err_code=4.
- BODY:
  - Each byte sampled with tx_en=1 enters a 5-byte delay line; length counter increments, saturating at 2047.
  - Once the line holds 5 bytes, each new byte pushes out the oldest.
  - Latency: body byte n appears on out_data/out_valid=1 in the cycle after the edge that sampled body byte n+5.
  - out_sop=1 on byte 0 only.
- End of frame (tx_en sampled 0 in BODY):
  - In the next cycle the line holds the last data byte plus 4 FCS bytes.
  - The last data byte is output with out_valid=out_eop=1.
  - frame_done, frame_ok and err_code are asserted in that same cycle.
  - State → IDLE.
- Body of 4 bytes or fewer: no out_valid at all; frame_done with err_code=2.
- Body of exactly 5 bytes: the single data byte is output with out_sop=out_eop=1.
- CRC32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, data processed LSB first, final complement.
  - Computed over the data bytes only, which are exactly the bytes output.
  - Received FCS is compared little-endian: first FCS byte = crc[7:0].
- Error priority: GIANT (len>MAX_LEN) > RUNT (len<MIN_LEN) > CRC mismatch.
  - Data is forwarded regardless of error.
  - No truncation at MAX_LEN.
- Counters: frm_cnt +1 when frame_done && frame_ok; err_cnt +1 when frame_done && !frame_ok; both hold at 0xFFFF.
- Output registers: out_valid, out_sop, out_eop and frame_done are single-cycle and deassert when there is no event.
- Inter-frame gap:
  - Minimum 1 idle cycle.
  - A preamble byte sampled in the eop cycle (state IDLE) starts a new frame normally.
  - The delay line is flushed at eop.

Test Plan:
- MIN_LEN=8; preamble 7×0x55, 0xD5, data 0x31..0x39, FCS 26 39 F4 CB, tx_en drop → out bytes 31..39 with sop on 31, eop on 39; frame_done, frame_ok=1, err_code=0, frm_cnt=1.
- Same frame with last FCS byte 0xCA → identical data output; frame_ok=0, err_code=1, err_cnt=1.
- Same frame, default MIN_LEN=64 → data forwarded, err_code=2; frame of 0x55×7, 0xD5, 3 bytes → no out_valid, err_code=2.
- 1 × 0x55 then 0xD5 (PRE_MIN=2) → DROP, no out_valid, frame_done on tx_en drop with err_code=4; payload bytes 0x55 from IDLE then 0x12 → err_code=4.
- Two good frames separated by a 1-cycle gap → two eop/frame_done pulses, frm_cnt=2, no byte mixing; 1600-byte body → err_code=3.
- rst=1 for one cycle mid-BODY → all outputs 0 next cycle, no frame_done; next clean frame passes with frm_cnt=1.
